pattern_sequencer: RTL

Selects which test pattern the video pattern generator draws, from debounced user buttons (next/prev), and optionally auto-cycles through patterns.
Requests are held pending and applied only at the start of vertical blanking, so a pattern never changes mid-frame.
Sits between the HPS/joystick button bits and the pattern generator's pattern-select input, on the same clock as the pixel-enable divider.

---
 rtl/video_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 56 +++++
 rtl/pattern_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg: shared encodings for the pattern sequencer and pattern generator
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } seq_state_e;

  typedef enum logic {
    DIR_NEXT = 1'b0,
    DIR_PREV = 1'b1
  } dir_e;

  localparam int NUM_PATTERNS_DEF = 6;
  localparam int SEL_W_DEF        = 4;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce: 2-flop synchronizer, stability counter, rising-edge press pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flip;

  // The level flips on the DEBOUNCE-th consecutive cycle that disagrees with it
  assign flip = (sync2_q != level_q) && (cnt_q == CNT_W'(DEBOUNCE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= flip & ~level_q;
      if (sync2_q != level_q) begin
        if (flip) begin
          level_q <= ~level_q;
          cnt_q   <= '0;
        end else begin
          cnt_q   <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer: button-driven test-pattern select, applied at vblank start
// Optional auto-cycle: define PATTERN_SEQUENCER_AUTO_CYCLE_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pattern_sequencer
  import video_pkg::*;
#(
  parameter int NUM_PATTERNS = NUM_PATTERNS_DEF,
  parameter int SEL_W        = SEL_W_DEF,
  parameter int DEBOUNCE     = 65536,
  parameter int AUTO_FRAMES  = 300
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             vblank,
  output logic [SEL_W-1:0] pattern_sel,
  output logic             pattern_strobe,
  output logic             pending
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_PATTERNS - 1);

  logic       press_next;
  logic       press_prev;
  logic       btn_req;
  dir_e       btn_dir;
  logic       vblank_d_q;
  logic       vb_rise;
  logic       auto_req;

  seq_state_e       state_q,   state_d;
  dir_e             dir_q,     dir_d;
  logic             relatch_q, relatch_d;
  logic [SEL_W-1:0] sel_q,     sel_d;

  function automatic logic [SEL_W-1:0] step(input logic [SEL_W-1:0] s, input dir_e d);
    if (d == DIR_NEXT) return (s == LAST_SEL) ? '0 : s + 1'b1;
    else               return (s == '0) ? LAST_SEL : s - 1'b1;
  endfunction

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_next (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_next),
    .press_o (press_next)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_prev (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_prev),
    .press_o (press_prev)
  );

  // Simultaneous next+prev cancel each other out
  assign btn_req = press_next ^ press_prev;
  assign btn_dir = press_prev ? DIR_PREV : DIR_NEXT;
  assign vb_rise = vblank & ~vblank_d_q;

`ifdef PATTERN_SEQUENCER_AUTO_CYCLE_EN
  localparam int FCNT_W = $clog2(AUTO_FRAMES + 1);

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // The injected request coincides with vb_rise, so it is applied this blanking
  always_comb begin
    fcnt_d   = fcnt_q;
    auto_req = 1'b0;
    if (press_next | press_prev) begin
      fcnt_d = '0;
    end else if (vb_rise && (state_q == ST_IDLE)) begin
      if (fcnt_q == FCNT_W'(AUTO_FRAMES - 1)) begin
        fcnt_d   = '0;
        auto_req = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fcnt_q <= '0;
    else       fcnt_q <= fcnt_d;
  end
`else
  assign auto_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_NEXT;
      relatch_q  <= 1'b0;
      sel_q      <= '0;
      vblank_d_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      relatch_q  <= relatch_d;
      sel_q      <= sel_d;
      vblank_d_q <= vblank;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    relatch_d = relatch_q;
    sel_d     = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (auto_req) begin
          sel_d     = step(sel_q, DIR_NEXT);
          relatch_d = 1'b0;
          state_d   = ST_APPLY;
        end else if (btn_req) begin
          dir_d   = btn_dir;
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // The old direction is applied; a request in the same cycle waits a frame
        if (vb_rise) begin
          sel_d     = step(sel_q, dir_q);
          relatch_d = btn_req;
          state_d   = ST_APPLY;
        end
        if (btn_req) dir_d = btn_dir;
      end
      ST_APPLY: begin
        if (btn_req) dir_d = btn_dir;
        relatch_d = 1'b0;
        state_d   = (btn_req || relatch_q) ? ST_PENDING : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pattern_sel    = sel_q;
    pattern_strobe = (state_q == ST_APPLY);
    pending        = (state_q == ST_PENDING);
  end

endmodule

`default_nettype wire
